// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shift mode encodings, FSM state codes and mode helpers for univ_shift_reg
package shift_reg_pkg;

   localparam logic [2:0] MODE_HOLD = 3'd0;
   localparam logic [2:0] MODE_SRL  = 3'd1;
   localparam logic [2:0] MODE_SLL  = 3'd2;
   localparam logic [2:0] MODE_ROR  = 3'd3;
   localparam logic [2:0] MODE_ROL  = 3'd4;
   localparam logic [2:0] MODE_SRA  = 3'd5;
   localparam logic [2:0] MODE_SRI  = 3'd6;
   localparam logic [2:0] MODE_SLI  = 3'd7;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic is_left(input logic [2:0] m);
      return (m == MODE_SLL) || (m == MODE_ROL) || (m == MODE_SLI);
   endfunction

endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: combinational one-position shifter shared by single-step and burst paths
module shift_reg_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value,
   input  logic [2:0]       mode,
   input  logic             ser_in,
   output logic [WIDTH-1:0] shifted,
   output logic             out_bit
);

   always_comb begin
      shifted = value;
      out_bit = is_left(mode) ? value[WIDTH-1] : value[0];
      case (mode)
         MODE_SRL: shifted = {1'b0, value[WIDTH-1:1]};
         MODE_SLL: shifted = {value[WIDTH-2:0], 1'b0};
         MODE_ROR: shifted = {value[0], value[WIDTH-1:1]};
         MODE_ROL: shifted = {value[WIDTH-2:0], value[WIDTH-1]};
         MODE_SRA: shifted = {value[WIDTH-1], value[WIDTH-1:1]};
         MODE_SRI: shifted = {ser_in, value[WIDTH-1:1]};
         MODE_SLI: shifted = {value[WIDTH-2:0], ser_in};
         default:  shifted = value;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with parallel load, single-step shifts and
// counted bursts with busy/done handshake
module univ_shift_reg
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d_in,
   input  logic [2:0]       mode,
   input  logic             shift_en,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             ser_in,
   output logic [WIDTH-1:0] d_out,
   output logic             ser_out,
   output logic             busy,
   output logic             done
);

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       mode_q, mode_nx, step_mode;
   logic             done_nx, do_shift, out_bit, ser_nx;
   logic [WIDTH-1:0] shifted, d_nx;

   // a running burst keeps the mode latched at start, ignoring the live input
   assign step_mode = (state == ST_BUSY) ? mode_q : mode;

   shift_reg_step #(.WIDTH(WIDTH)) u_step (
      .value   (d_out),
      .mode    (step_mode),
      .ser_in  (ser_in),
      .shifted (shifted),
      .out_bit (out_bit)
   );

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      mode_nx  = mode_q;
      done_nx  = 1'b0;
      do_shift = 1'b0;
      if (load) begin
         state_nx = ST_IDLE;
         cnt_nx   = '0;
      end else if (state == ST_BUSY) begin
         do_shift = 1'b1;
         cnt_nx   = cnt - 1'b1;
         if (cnt == CNT_W'(1)) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
         end
      end else if (start) begin
         mode_nx  = mode;
         cnt_nx   = count;
         state_nx = (count == '0) ? ST_IDLE : ST_BUSY;
         done_nx  = (count == '0);
      end else begin
         do_shift = shift_en;
      end
   end

   assign d_nx   = load ? d_in : (do_shift ? shifted : d_out);
   assign ser_nx = (do_shift && step_mode != MODE_HOLD) ? out_bit : ser_out;
   assign busy   = (state == ST_BUSY);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         mode_q  <= MODE_HOLD;
         d_out   <= '0;
         ser_out <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         mode_q  <= mode_nx;
         d_out   <= d_nx;
         ser_out <= ser_nx;
         done    <= done_nx;
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed and randomized checks of univ_shift_reg against an arithmetic model
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       load = 1'b0;
   logic [7:0] d_in = '0;
   logic [2:0] mode = '0;
   logic       shift_en = 1'b0;
   logic       start = 1'b0;
   logic [3:0] count = '0;
   logic       ser_in = 1'b0;
   logic [7:0] d_out;
   logic       ser_out, busy, done;

   int vecs = 0;
   int errs = 0;
   logic [7:0] m_val;
   logic       m_ser;

   univ_shift_reg #(.WIDTH(8)) dut (
      .clock(clk), .reset_n(reset_n), .load(load), .d_in(d_in), .mode(mode),
      .shift_en(shift_en), .start(start), .count(count), .ser_in(ser_in),
      .d_out(d_out), .ser_out(ser_out), .busy(busy), .done(done)
   );

   always #50 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL timeout: simulation ran past its time budget");
      $fatal(1, "timeout");
   end

   // one shift of the model value, expressed as plain arithmetic on the register as a number
   task automatic ref_step(input logic [2:0] md, input logic si);
      int v, nv, ob;
      v  = int'(m_val);
      nv = v;
      ob = int'(m_ser);
      case (md)
         3'd1: begin nv = v / 2;                        ob = v % 2;   end
         3'd2: begin nv = (v * 2) % 256;                ob = v / 128; end
         3'd3: begin nv = v / 2 + (v % 2) * 128;        ob = v % 2;   end
         3'd4: begin nv = (v * 2) % 256 + v / 128;      ob = v / 128; end
         3'd5: begin nv = v / 2 + (v / 128) * 128;      ob = v % 2;   end
         3'd6: begin nv = v / 2 + int'(si) * 128;       ob = v % 2;   end
         3'd7: begin nv = (v * 2) % 256 + int'(si);     ob = v / 128; end
         default: ;
      endcase
      m_val = 8'(nv);
      m_ser = ob[0];
   endtask

   task automatic test_reset();
      @(negedge clk) reset_n = 1'b1; load = 1'b1; d_in = 8'hA5;
      @(negedge clk) load = 1'b0;
      vecs++;
      if (d_out !== 8'hA5) begin errs++; $display("FAIL reset_preload: d_out=%h exp=%h", d_out, 8'hA5); end
      #20 reset_n = 1'b0;
      #1;
      vecs++;
      if (d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || ser_out !== 1'b0) begin
         errs++;
         $display("FAIL reset_async: d_out=%h busy=%b done=%b ser_out=%b exp 00/0/0/0", d_out, busy, done, ser_out);
      end
      #10 reset_n = 1'b1;
   endtask

   task automatic test_load_hold();
      @(negedge clk) load = 1'b1; d_in = 8'h55;
      @(negedge clk) load = 1'b0;
      vecs++;
      if (d_out !== 8'h55) begin errs++; $display("FAIL load55: d_out=%h exp=55", d_out); end
      mode = 3'd0; shift_en = 1'b1;
      @(negedge clk) shift_en = 1'b0;
      vecs++;
      if (d_out !== 8'h55 || ser_out !== 1'b0) begin
         errs++; $display("FAIL hold: d_out=%h ser_out=%b exp=55/0", d_out, ser_out);
      end
   endtask

   task automatic test_single_step();
      @(negedge clk) load = 1'b1; d_in = 8'hCC;
      @(negedge clk) load = 1'b0; mode = 3'd1; shift_en = 1'b1;
      @(negedge clk) mode = 3'd7; ser_in = 1'b1;
      vecs++;
      if (d_out !== 8'h66 || ser_out !== 1'b0) begin
         errs++; $display("FAIL srl_step: d_out=%h ser_out=%b exp=66/0", d_out, ser_out);
      end
      @(negedge clk) shift_en = 1'b0; ser_in = 1'b0;
      vecs++;
      if (d_out !== 8'hCD || ser_out !== 1'b0 || busy !== 1'b0) begin
         errs++; $display("FAIL sli_step: d_out=%h ser_out=%b busy=%b exp=cd/0/0", d_out, ser_out, busy);
      end
   endtask

   task automatic test_burst_full();
      logic [7:0] exp;
      @(negedge clk) load = 1'b1; d_in = 8'hFF;
      @(negedge clk) load = 1'b0; start = 1'b1; mode = 3'd1; count = 4'd8;
      @(negedge clk) start = 1'b0; mode = 3'd0;
      vecs++;
      if (busy !== 1'b1 || done !== 1'b0 || d_out !== 8'hFF) begin
         errs++; $display("FAIL burst8_start: busy=%b done=%b d_out=%h exp 1/0/ff", busy, done, d_out);
      end
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp = 8'hFF >> k;
         vecs++;
         if (d_out !== exp || busy !== (k < 8) || done !== (k == 8)) begin
            errs++;
            $display("FAIL burst8_step%0d: d_out=%h busy=%b done=%b exp %h/%b/%b", k, d_out, busy, done, exp, k < 8, k == 8);
         end
      end
      @(negedge clk);
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL burst8_after: done=%b busy=%b exp 0/0", done, busy); end
   endtask

   task automatic run_burst(input logic [7:0] v, input logic [2:0] md, input logic [3:0] n, input logic [7:0] exp, input string nm);
      @(negedge clk) load = 1'b1; d_in = v;
      @(negedge clk) load = 1'b0; start = 1'b1; mode = md; count = n;
      @(negedge clk) start = 1'b0; mode = 3'd0;
      repeat (int'(n)) @(negedge clk);
      vecs++;
      if (d_out !== exp || done !== 1'b1 || busy !== 1'b0) begin
         errs++; $display("FAIL %s: d_out=%h done=%b busy=%b exp %h/1/0", nm, d_out, done, busy, exp);
      end
   endtask

   task automatic test_burst_misc();
      bit saw_busy;
      run_burst(8'hA5, 3'd3, 4'd4, 8'h5A, "ror4");
      run_burst(8'h80, 3'd5, 4'd3, 8'hF0, "sra3");
      run_burst(8'h81, 3'd4, 4'd11, 8'h0C, "rol11_wrap");
      run_burst(8'h96, 3'd2, 4'd12, 8'h00, "sll12_over");
      @(negedge clk) start = 1'b1; mode = 3'd1; count = 4'd0;
      @(negedge clk) start = 1'b0;
      saw_busy = busy;
      vecs++;
      if (done !== 1'b1 || d_out !== 8'h00 || saw_busy) begin
         errs++; $display("FAIL count0: done=%b busy=%b d_out=%h exp 1/0/00", done, busy, d_out);
      end
      @(negedge clk);
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL count0_after: done=%b busy=%b exp 0/0", done, busy); end
   endtask

   task automatic test_abort();
      @(negedge clk) load = 1'b1; d_in = 8'hFF;
      @(negedge clk) load = 1'b0; start = 1'b1; mode = 3'd1; count = 4'd8;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      load = 1'b1; d_in = 8'h3C;
      @(negedge clk) load = 1'b0;
      vecs++;
      if (d_out !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
         errs++; $display("FAIL load_abort: d_out=%h busy=%b done=%b exp 3c/0/0", d_out, busy, done);
      end
      repeat (6) begin
         @(negedge clk);
         vecs++;
         if (d_out !== 8'h3C || done !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL load_abort_tail: d_out=%h busy=%b done=%b exp 3c/0/0", d_out, busy, done);
         end
      end
      @(negedge clk) load = 1'b1; d_in = 8'hFF;
      @(negedge clk) load = 1'b0; start = 1'b1; mode = 3'd1; count = 4'd8;
      @(negedge clk) start = 1'b0;
      repeat (2) @(negedge clk);
      #20 reset_n = 1'b0;
      #1;
      vecs++;
      if (d_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         errs++; $display("FAIL reset_abort: d_out=%h busy=%b done=%b exp 00/0/0", d_out, busy, done);
      end
      #10 reset_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         vecs++;
         if (d_out !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
            errs++; $display("FAIL reset_abort_tail: d_out=%h busy=%b done=%b exp 00/0/0", d_out, busy, done);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0] md;
      logic [3:0] n;
      logic       si;
      @(negedge clk) reset_n = 1'b0;
      #10 reset_n = 1'b1;
      m_val = 8'h00;
      m_ser = 1'b0;
      for (int r = 0; r < 40; r++) begin
         if ($urandom_range(1, 0) == 1) begin
            @(negedge clk) load = 1'b1; d_in = 8'($urandom); shift_en = 1'($urandom);
            m_val = d_in;
            @(negedge clk) load = 1'b0; shift_en = 1'b0;
            vecs++;
            if (d_out !== m_val || ser_out !== m_ser) begin
               errs++; $display("FAIL rnd_load: d_out=%h ser_out=%b exp %h/%b", d_out, ser_out, m_val, m_ser);
            end
         end
         repeat ($urandom_range(3, 0)) begin
            md = 3'($urandom); si = 1'($urandom);
            @(negedge clk) mode = md; ser_in = si; shift_en = 1'b1;
            @(negedge clk) shift_en = 1'b0;
            ref_step(md, si);
            vecs++;
            if (d_out !== m_val || ser_out !== m_ser || busy !== 1'b0 || done !== 1'b0) begin
               errs++;
               $display("FAIL rnd_step mode=%0d: d_out=%h ser_out=%b busy=%b done=%b exp %h/%b/0/0", md, d_out, ser_out, busy, done, m_val, m_ser);
            end
         end
         md = 3'($urandom);
         n  = 4'($urandom_range(15, 0));
         if (!done) @(negedge clk);
         start = 1'b1; mode = md; count = n; shift_en = 1'($urandom);
         @(negedge clk);
         vecs++;
         if (d_out !== m_val || busy !== (n != 0) || done !== (n == 0)) begin
            errs++;
            $display("FAIL rnd_start n=%0d: d_out=%h busy=%b done=%b exp %h/%b/%b", n, d_out, busy, done, m_val, n != 0, n == 0);
         end
         for (int k = 1; k <= int'(n); k++) begin
            si = 1'($urandom);
            mode = 3'($urandom); ser_in = si; start = 1'($urandom); shift_en = 1'($urandom);
            @(negedge clk);
            ref_step(md, si);
            vecs++;
            if (d_out !== m_val || ser_out !== m_ser || busy !== (k < int'(n)) || done !== (k == int'(n))) begin
               errs++;
               $display("FAIL rnd_burst mode=%0d n=%0d k=%0d: d_out=%h ser_out=%b busy=%b done=%b exp %h/%b/%b/%b",
                        md, n, k, d_out, ser_out, busy, done, m_val, m_ser, k < int'(n), k == int'(n));
            end
         end
         start = 1'b0; shift_en = 1'b0;
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_load_hold();
      test_single_step();
      test_burst_full();
      test_burst_misc();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
